// File: rtl/kbd_event_queue_pkg.sv
// ============================================================================
// Module      : kbd_event_queue_pkg
// Description : Register map, status bit layout and interrupt FSM encodings
//               shared by the keyboard event queue.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package kbd_event_queue_pkg;

    localparam logic [63:0] C_KEY_BASE_DEFAULT = 64'h0000_0000_0000_4000;
    localparam logic [63:0] C_KEY_DATA_OFF     = 64'd0;
    localparam logic [63:0] C_KEY_STAT_OFF     = 64'd8;

    localparam int C_ENTRY_W          = 16;
    localparam int C_DATA_VALID_BIT   = 31;
    localparam int C_STAT_OVERFLOW_BIT = 18;
    localparam int C_STAT_FULL_BIT    = 17;
    localparam int C_STAT_EMPTY_BIT   = 16;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_PEND = 2'd1;
    localparam logic [1:0] C_ST_WAIT = 2'd2;

    function automatic logic [63:0] f_data_word(input logic [C_ENTRY_W-1:0] entry);
        logic [63:0] w;
        w = '0;
        w[C_DATA_VALID_BIT] = 1'b1;
        w[C_ENTRY_W-1:0]    = entry;
        return w;
    endfunction

    function automatic logic [63:0] f_status_word(input logic       overflow,
                                                  input logic       full,
                                                  input logic       empty,
                                                  input logic [6:0] count);
        logic [63:0] w;
        w = '0;
        w[C_STAT_OVERFLOW_BIT] = overflow;
        w[C_STAT_FULL_BIT]     = full;
        w[C_STAT_EMPTY_BIT]    = empty;
        w[6:0]                 = count;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_event_queue_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular FIFO with a registered head word.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_do_push;
    logic             w_do_pop;
    logic [C_AW-1:0]  w_rd_next;

    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | pop);
    assign w_rd_next = r_rd_ptr + C_AW'(w_do_pop);

    assign full  = (r_count == (C_AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_next;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage and head register carry no reset so they map onto block RAM;
    // the bypass covers a write landing on the slot that becomes the head.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
        if (w_do_push && (r_wr_ptr == w_rd_next)) r_head <= din;
        else                                      r_head <= r_mem[w_rd_next];
    end

endmodule

`default_nettype wire

// File: rtl/kbd_event_queue.sv
// ============================================================================
// Module      : kbd_event_queue
// Description : Buffers decoder key events, serves them on the CPU bus and
//               drives the keyboard interrupt request/acknowledge handshake.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module kbd_event_queue
    import kbd_event_queue_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [63:0] KEY_BASE = C_KEY_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_pressed,
    input  logic [7:0]  ascii,
    input  logic [7:0]  scan,
    input  logic [63:0] bus_address,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    output logic        bus_read_hit,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_ack
);

    localparam int C_CW = $clog2(DEPTH) + 1;

    logic                 r_key_d;
    logic                 r_data_sel_d;
    logic                 r_stat_sel_d;
    logic                 r_overflow;
    logic [63:0]          r_rd_data;
    logic                 r_hit;
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;

    logic                 w_key_edge;
    logic                 w_data_sel;
    logic                 w_stat_sel;
    logic                 w_data_edge;
    logic                 w_stat_edge;
    logic                 w_pop;
    logic [C_ENTRY_W-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [C_CW-1:0]      w_count;
    logic [6:0]           w_count7;

    assign w_key_edge  = key_pressed & ~r_key_d & (ascii != 8'd0);
    assign w_data_sel  = bus_read_enable & (bus_address == KEY_BASE + C_KEY_DATA_OFF);
    assign w_stat_sel  = bus_read_enable & (bus_address == KEY_BASE + C_KEY_STAT_OFF);
    assign w_data_edge = w_data_sel & ~r_data_sel_d;
    assign w_stat_edge = w_stat_sel & ~r_stat_sel_d;
    assign w_pop       = w_data_edge & ~w_empty;
    assign w_count7    = 7'(w_count);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (C_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_key_edge),
        .pop   (w_data_edge),
        .din   ({scan, ascii}),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_d      <= 1'b0;
            r_data_sel_d <= 1'b0;
            r_stat_sel_d <= 1'b0;
            r_overflow   <= 1'b0;
            r_rd_data    <= '0;
            r_hit        <= 1'b0;
        end else begin
            r_key_d      <= key_pressed;
            r_data_sel_d <= w_data_sel;
            r_stat_sel_d <= w_stat_sel;
            r_hit        <= w_data_sel | w_stat_sel;

            // A new overflow in the same cycle as a status read is kept.
            if (w_key_edge && w_full && !w_data_edge) r_overflow <= 1'b1;
            else if (w_stat_edge)                     r_overflow <= 1'b0;

            if (w_data_edge)
                r_rd_data <= w_empty ? 64'd0 : f_data_word(w_head);
            else if (w_stat_edge)
                r_rd_data <= f_status_word(r_overflow, w_full, w_empty, w_count7);
            else if (!(w_data_sel || w_stat_sel))
                r_rd_data <= '0;
        end
    end

    assign bus_read_data = r_rd_data;
    assign bus_read_hit  = r_hit;

    always_ff @(posedge clk) begin
        if (reset) r_state <= C_ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        interrupt_vector = 4'd0;
        case (r_state)
            C_ST_IDLE: if (w_count != '0) w_state_next = C_ST_PEND;
            C_ST_PEND: begin
                interrupt_vector = 4'd1;
                if (interrupt_ack) w_state_next = C_ST_WAIT;
            end
            C_ST_WAIT: if (w_pop) w_state_next = C_ST_IDLE;
            default:   w_state_next = C_ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_kbd_event_queue.sv
// ============================================================================
// Module      : tb_kbd_event_queue
// Description : Scoreboard bench for kbd_event_queue with directed key events.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_kbd_event_queue;

    localparam logic [63:0] KB   = 64'h0000_0000_0000_4000;
    localparam logic [63:0] KS   = KB + 64'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_pressed;
    logic [7:0]  ascii;
    logic [7:0]  scan;
    logic [63:0] bus_address;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic        bus_read_hit;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    string       tag_q[$];

    kbd_event_queue #(
        .DEPTH    (8),
        .KEY_BASE (KB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .key_pressed      (key_pressed),
        .ascii            (ascii),
        .scan             (scan),
        .bus_address      (bus_address),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .bus_read_hit     (bus_read_hit),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack)
    );

    always #5 clk = ~clk;

    // Monitor: every registered hit consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset && bus_read_hit) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_hit actual %h required no read", bus_read_data);
            end else begin
                logic [63:0] e;
                string       t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (bus_read_data !== e) begin
                    errors++;
                    $display("FAIL %s actual %h required %h", t, bus_read_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [3:0] e);
        checks++;
        if (interrupt_vector !== e) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, interrupt_vector, e);
        end
    endtask

    function automatic logic [63:0] dword(input logic [7:0] s, input logic [7:0] a);
        return {32'h0, 16'h8000, s, a};
    endfunction

    task automatic do_read(input logic [63:0] addr, input int n,
                           input logic [63:0] e, input string name);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            tag_q.push_back(name);
        end
        cyc(n);
        bus_read_enable = 1'b0;
        cyc(1);
    endtask

    task automatic press(input logic [7:0] s, input logic [7:0] a);
        scan        = s;
        ascii       = a;
        key_pressed = 1'b1;
        cyc(1);
        key_pressed = 1'b0;
        cyc(1);
    endtask

    task automatic do_ack();
        interrupt_ack = 1'b1;
        cyc(1);
        interrupt_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        key_pressed = 0; ascii = 0; scan = 0; bus_address = 0;
        bus_read_enable = 0; interrupt_ack = 0;
        do_reset();

        // Reset state
        checks++;
        if (bus_read_data !== 64'd0 || bus_read_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs actual %h/%b required 0/0", bus_read_data, bus_read_hit);
        end
        check_vec("reset_vec", 4'd0);
        do_read(KB, 1, 64'd0, "empty_data");
        do_read(KS, 1, 64'h0000_0000_0001_0000, "reset_status");

        // Single key, ack, held read
        scan = 8'h1C; ascii = 8'h61; key_pressed = 1'b1;
        cyc(1);
        key_pressed = 1'b0;
        check_vec("vec_n1", 4'd0);
        cyc(1);
        check_vec("vec_n2", 4'd1);
        do_ack();
        check_vec("vec_after_ack", 4'd0);
        do_read(KB, 20, 64'h0000_0000_8000_1C61, "held_data");
        do_read(KS, 1, 64'h0000_0000_0001_0000, "status_after_held");
        check_vec("vec_idle_after_pop", 4'd0);

        // Key held for 100 cycles
        scan = 8'h16; ascii = 8'h31; key_pressed = 1'b1;
        cyc(100);
        key_pressed = 1'b0;
        cyc(1);
        do_read(KS, 1, 64'h0000_0000_0000_0001, "held_key_status");
        check_vec("held_key_vec", 4'd1);
        do_ack();
        do_read(KB, 1, dword(8'h16, 8'h31), "held_key_data");
        check_vec("held_key_vec_idle", 4'd0);

        // ascii zero is ignored
        press(8'h12, 8'h00);
        do_read(KS, 1, 64'h0000_0000_0001_0000, "ascii0_status");

        // Overflow with nine keys
        for (int i = 1; i <= 9; i++) press(8'(8'h10 + i), 8'(8'h40 + i));
        do_read(KS, 1, 64'h0000_0000_0006_0008, "ovf_status1");
        do_read(KS, 1, 64'h0000_0000_0002_0008, "ovf_status2");
        check_vec("ovf_vec", 4'd1);
        do_ack();
        for (int i = 1; i <= 8; i++) do_read(KB, 1, dword(8'(8'h10 + i), 8'(8'h40 + i)), "ovf_data");
        do_read(KB, 1, 64'd0, "ovf_ninth_empty");

        // Interrupt re-assert after a pop in WAIT
        do_reset();
        for (int i = 1; i <= 3; i++) press(8'(8'h30 + i), 8'(8'h60 + i));
        check_vec("irq3_pend", 4'd1);
        do_ack();
        check_vec("irq3_ack", 4'd0);
        bus_address = KB; bus_read_enable = 1'b1;
        exp_q.push_back(dword(8'h31, 8'h61)); tag_q.push_back("irq3_pop1");
        exp_q.push_back(dword(8'h31, 8'h61)); tag_q.push_back("irq3_pop1");
        cyc(1);
        check_vec("irq3_idle_n1", 4'd0);
        cyc(1);
        check_vec("irq3_reassert_n2", 4'd1);
        bus_read_enable = 1'b0;
        cyc(1);
        do_ack();
        check_vec("irq3_ack2", 4'd0);
        do_read(KB, 1, dword(8'h32, 8'h62), "irq3_pop2");
        check_vec("irq3_reassert2", 4'd1);
        do_ack();
        do_read(KB, 1, dword(8'h33, 8'h63), "irq3_pop3");
        cyc(2);
        check_vec("irq3_final_idle", 4'd0);
        do_read(KS, 1, 64'h0000_0000_0001_0000, "irq3_status");

        // Full FIFO: push and pop in the same cycle
        do_reset();
        for (int i = 1; i <= 8; i++) press(8'(8'h20 + i), 8'(8'h50 + i));
        scan = 8'h2F; ascii = 8'h7A; key_pressed = 1'b1;
        bus_address = KB; bus_read_enable = 1'b1;
        exp_q.push_back(dword(8'h21, 8'h51)); tag_q.push_back("full_simul_data");
        cyc(1);
        key_pressed = 1'b0; bus_read_enable = 1'b0;
        cyc(1);
        do_read(KS, 1, 64'h0000_0000_0002_0008, "full_simul_status");
        for (int i = 2; i <= 8; i++) do_read(KB, 1, dword(8'(8'h20 + i), 8'(8'h50 + i)), "full_drain");
        do_read(KB, 1, dword(8'h2F, 8'h7A), "full_new_key");
        do_read(KS, 1, 64'h0000_0000_0001_0000, "full_final_status");

        cyc(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_reads actual %0d left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/kbd_event_queue.md
# kbd_event_queue

Buffers key events from `ps2_decoder` and serves them to the CPU bus and interrupt controller. It sits between the decoder outputs (`ascii`, `scan`, `key_pressed`) and the bus read-data multiplexer. It replaces direct sampling of the live `ascii` register, so keystrokes are no longer lost while the slow CPU clock is between instructions. It also owns the keyboard interrupt request/acknowledge handshake.

## Interface
- `DEPTH`, 8: event slots; power of two, 2..64.
- `KEY_BASE`, `` `Key_base `` (header.vh): data register address; the status register is at `KEY_BASE+8`.
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: synchronous, active-high.
- `key_pressed` in 1: decoder make-event level.
- `ascii` in 8: decoder ASCII code.
- `scan` in 8: decoder scan code.
- `bus_address` in 64: CPU bus address.
- `bus_read_enable` in 1: CPU read strobe; a level that may be held for many clk cycles.
- `bus_read_data` out 64: registered read data.
- `bus_read_hit` out 1: registered; high when `bus_read_data` comes from this block.
- `interrupt_vector` out 4: 1 = key pending, 0 = none.
- `interrupt_ack` in 1: CPU acknowledge.

## Operation
- Storage is a circular FIFO of `DEPTH` entries, each `{scan, ascii}` (16 bits).
  - Pointers are `log2(DEPTH)` bits and wrap naturally.
  - `count` is `log2(DEPTH)+1` bits.
- Push occurs on the clk where `key_pressed`=1, the registered `key_pressed` of the previous cycle = 0, and `ascii`≠0.
  - One push per make event.
  - If full, the event is dropped and sticky `overflow` is set.
- Data read: `bus_read_enable` && `bus_address`==`KEY_BASE`.
  - Non-empty: `bus_read_data` = {32'd0, 1'b1 (valid, bit 31), 15'd0, scan, ascii}.
  - Empty: `bus_read_data` = all zeros.
- Status read: address `KEY_BASE+8`.
  - `bus_read_data` = {45'd0, overflow[18], full[17], empty[16], 9'd0, count[6:0] zero-extended}.
- Pop and overflow clear fire only on the first cycle of a read (rising edge of the select-qualified enable).
  - A data read pops one entry if non-empty.
  - A status read clears `overflow` after it has been captured.
- Held enable: `bus_read_data` is captured on the first cycle and held unchanged while the enable stays high at the same address.
- Enable low or address miss: `bus_read_data`=0 and `bus_read_hit`=0.
- Interrupt FSM:
  - IDLE → PEND when `count`≠0.
  - PEND → WAIT on `interrupt_ack`=1.
  - WAIT → IDLE on a pop.
  - `interrupt_vector`=1 only in PEND.
  - `interrupt_ack` has no effect in IDLE and WAIT.
- Simultaneous push and pop:
  - Both take effect; `count` is unchanged.
  - When full, the push is accepted, because the pop frees a slot in the same cycle.
  - When empty, the pop is ignored and the push is accepted.

## Timing
- Reset values: `bus_read_data`=0, `bus_read_hit`=0, `interrupt_vector`=0, FSM=IDLE. Pointers, `count`, and `overflow` clear; the edge-detect registers clear. FIFO RAM contents are not reset.
- Read latency is 1 clk: address and enable in cycle N, data valid in N+1.
- Pop takes effect at the end of cycle N. A fresh read edge at N+1 or later sees the next entry.
- Push occurs in cycle N: `count` and `empty` reflect it from N+1. `interrupt_vector` rises at N+2 (FSM reacts to registered `count`).
- Ack at cycle N: `interrupt_vector`=0 from N+1.
- After a pop in WAIT with entries remaining: IDLE at N+1, PEND at N+2, so the vector re-asserts.
- Reset mid-read or mid-interrupt: reset wins in the same cycle and all state is cleared.

## Structure
- Shared package/header: `KEY_BASE` offsets (`KEY_DATA_OFF`=0, `KEY_STAT_OFF`=8), status bit positions, and FSM state encodings (IDLE=0, PEND=1, WAIT=2).
- One sub-module, `sync_fifo` (DEPTH, WIDTH): push/pop/full/empty/count, RAM inferable as block RAM with a registered head output. The top handles edge detection, bus decode and the FSM.

## Test plan
- Reset, then a data read → `bus_read_data`=0, `interrupt_vector`=0, status = empty set, `count`=0.
- Single key (scan 0x1C, ascii 0x61), then ack, then a data read held for 20 clk:
  - `interrupt_vector`=1 two cycles after the push, and 0 after ack.
  - Read returns 0x8000_1C61 every held cycle.
  - Only one pop; `count`=0 afterwards.
- `key_pressed` held high for 100 clk → exactly one entry.
- `ascii`=0 with `key_pressed` → no push.
- Push 9 keys with DEPTH=8:
  - Status shows `count`=8, full=1, overflow=1.
  - A second status read shows overflow=0.
  - Eight data reads return keys 1..8 in order.
  - The ninth data read returns 0.
- Push 3 keys, ack, pop one:
  - Vector re-asserts two cycles after the pop.
  - Ack again and pop twice → FSM ends in IDLE with vector 0.
- FIFO full, push and data-read edge in the same cycle → `count` stays 8, no overflow, and the last entry read is the new key.
